// File: rtl/tiled_loop_index_generator_pkg.sv
// Shared types for the tiled loop index generator: FIFO status bundle and FSM state encoding.
package CU_PKG;

   typedef struct packed {
      logic full;
      logic alfull;
      logic valid;
      logic empty;
   } BufferStatus;

   typedef enum logic [2:0] {IDLE, SETUP, GEN, DRAIN, DONE} tiled_loop_index_gen_state;

   // alfull rises once this many entries or fewer remain free
   localparam int FIFO_ALFULL_SLACK = 1;

endpackage

// File: rtl/tiled_loop_index_generator_fifo.sv
// First-word-fall-through output FIFO; head reads as zero whenever the FIFO is empty.
module fifo
   import CU_PKG::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 32
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output BufferStatus      status,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL   = (AW+1)'(DEPTH);
   localparam logic [AW:0] ALFULL_LVL = (AW+1)'(DEPTH - FIFO_ALFULL_SLACK);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok, pop_ok;

   always_comb begin
      status.empty  = (count_q == '0);
      status.valid  = !status.empty;
      status.full   = (count_q == FULL_LVL);
      status.alfull = (count_q >= ALFULL_LVL);
      pop_ok   = pop && status.valid;
      // a pop in the same cycle frees the slot a full FIFO needs
      push_ok  = push && (!status.full || pop_ok);
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop_ok);
      count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      head     = status.valid ? mem_q[rd_ptr_q] : '0;
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/tiled_loop_index_generator.sv
// Tiled 2-D loop index generator (base + i*outer_stride + j*inner_stride) feeding an output FIFO.
// Define TILED_LOOP_GEN_STATS_EN to add the saturating generated_count output.
module tiled_loop_index_generator
   import CU_PKG::*;
#(
   parameter int INDEX_WIDTH = 64,
   parameter int COUNT_WIDTH = 32,
   parameter int FIFO_DEPTH  = 32
) (
   input  logic                   clock,
   input  logic                   rst_in,
   input  logic                   enabled_in,
   input  logic                   start_in,
   input  logic [INDEX_WIDTH-1:0] base_index,
   input  logic [COUNT_WIDTH-1:0] outer_count,
   input  logic [COUNT_WIDTH-1:0] inner_count,
   input  logic [INDEX_WIDTH-1:0] outer_stride,
   input  logic [INDEX_WIDTH-1:0] inner_stride,
   input  logic                   index_request,
   output BufferStatus            index_buffer_status,
   output logic [INDEX_WIDTH-1:0] output_index,
   output logic                   busy,
   output logic                   index_done
`ifdef TILED_LOOP_GEN_STATS_EN
   ,
   output logic [2*COUNT_WIDTH-1:0] generated_count
`endif
);

   localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

   logic rst_meta_q, rst_q;
   tiled_loop_index_gen_state state_q, state_d;
   logic [INDEX_WIDTH-1:0] base_q, base_d, outer_str_q, outer_str_d, inner_str_q, inner_str_d;
   logic [INDEX_WIDTH-1:0] row_acc_q, row_acc_d, col_acc_q, col_acc_d;
   logic [COUNT_WIDTH-1:0] outer_cnt_q, outer_cnt_d, inner_cnt_q, inner_cnt_d;
   logic [COUNT_WIDTH-1:0] i_q, i_d, j_q, j_d;
   logic push, launch;

   // Reset asserts immediately and releases two clocks after rst_in falls.
   always_ff @(posedge clock or posedge rst_in) begin
      if (rst_in) begin
         rst_meta_q <= 1'b1;
         rst_q      <= 1'b1;
      end else begin
         rst_meta_q <= 1'b0;
         rst_q      <= rst_meta_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      outer_cnt_d = outer_cnt_q;
      inner_cnt_d = inner_cnt_q;
      outer_str_d = outer_str_q;
      inner_str_d = inner_str_q;
      i_d         = i_q;
      j_d         = j_q;
      row_acc_d   = row_acc_q;
      col_acc_d   = col_acc_q;
      push        = 1'b0;
      launch      = 1'b0;
      if (enabled_in) begin
         unique case (state_q)
            IDLE, DONE: launch = start_in;
            SETUP: begin
               i_d       = '0;
               j_d       = '0;
               row_acc_d = base_q;
               col_acc_d = base_q;
               state_d   = (outer_cnt_q == '0 || inner_cnt_q == '0) ? DONE : GEN;
            end
            GEN: begin
               if (!index_buffer_status.alfull) begin
                  push = 1'b1;
                  if (j_q == inner_cnt_q - CNT_ONE) begin
                     j_d = '0;
                     if (i_q == outer_cnt_q - CNT_ONE) begin
                        state_d = DRAIN;
                     end else begin
                        i_d       = i_q + CNT_ONE;
                        row_acc_d = row_acc_q + outer_str_q;
                        col_acc_d = row_acc_d;
                     end
                  end else begin
                     j_d       = j_q + CNT_ONE;
                     col_acc_d = col_acc_q + inner_str_q;
                  end
               end
            end
            DRAIN: if (index_buffer_status.empty) state_d = DONE;
            default: state_d = IDLE;
         endcase
         if (launch) begin
            state_d     = SETUP;
            base_d      = base_index;
            outer_cnt_d = outer_count;
            inner_cnt_d = inner_count;
            outer_str_d = outer_stride;
            inner_str_d = inner_stride;
         end
      end
   end

   always_ff @(posedge clock or posedge rst_q) begin
      if (rst_q) begin
         state_q     <= IDLE;
         base_q      <= '0;
         outer_cnt_q <= '0;
         inner_cnt_q <= '0;
         outer_str_q <= '0;
         inner_str_q <= '0;
         i_q         <= '0;
         j_q         <= '0;
         row_acc_q   <= '0;
         col_acc_q   <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         outer_cnt_q <= outer_cnt_d;
         inner_cnt_q <= inner_cnt_d;
         outer_str_q <= outer_str_d;
         inner_str_q <= inner_str_d;
         i_q         <= i_d;
         j_q         <= j_d;
         row_acc_q   <= row_acc_d;
         col_acc_q   <= col_acc_d;
      end
   end

`ifdef TILED_LOOP_GEN_STATS_EN
   logic [2*COUNT_WIDTH-1:0] gen_cnt_q, gen_cnt_d;

   always_comb begin
      gen_cnt_d = gen_cnt_q;
      if (launch) gen_cnt_d = '0;
      else if (push && gen_cnt_q != '1) gen_cnt_d = gen_cnt_q + (2*COUNT_WIDTH)'(1);
   end

   always_ff @(posedge clock or posedge rst_q) begin
      if (rst_q) gen_cnt_q <= '0;
      else       gen_cnt_q <= gen_cnt_d;
   end

   assign generated_count = gen_cnt_q;
`endif

   assign busy       = (state_q == SETUP) || (state_q == GEN) || (state_q == DRAIN);
   assign index_done = (state_q == DONE);

   fifo #(
      .WIDTH (INDEX_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .rst       (rst_q),
      .push      (push),
      .push_data (col_acc_q),
      .pop       (index_request),
      .status    (index_buffer_status),
      .head      (output_index)
   );

endmodule

// File: tb/tb_tiled_loop_index_generator.sv
// Self-checking bench for tiled_loop_index_generator against a nested-loop arithmetic model.
`timescale 1ns/1ps
module tb_tiled_loop_index_generator;
   import CU_PKG::*;

   logic        clock = 1'b0;
   logic        rst_in = 1'b1;
   logic        enabled_in = 1'b1;
   logic        start_in = 1'b0;
   logic [63:0] base_index = '0;
   logic [31:0] outer_count = '0;
   logic [31:0] inner_count = '0;
   logic [63:0] outer_stride = '0;
   logic [63:0] inner_stride = '0;
   logic        index_request = 1'b0;
   BufferStatus index_buffer_status;
   logic [63:0] output_index;
   logic        busy;
   logic        index_done;
`ifdef TILED_LOOP_GEN_STATS_EN
   logic [63:0] generated_count;
`endif

   int checks = 0;
   int failures = 0;
   logic [63:0] exp_q[$];
   logic [63:0] got[$];

   tiled_loop_index_generator dut (
      .clock               (clock),
      .rst_in              (rst_in),
      .enabled_in          (enabled_in),
      .start_in            (start_in),
      .base_index          (base_index),
      .outer_count         (outer_count),
      .inner_count         (inner_count),
      .outer_stride        (outer_stride),
      .inner_stride        (inner_stride),
      .index_request       (index_request),
      .index_buffer_status (index_buffer_status),
      .output_index        (output_index),
      .busy                (busy),
      .index_done          (index_done)
`ifdef TILED_LOOP_GEN_STATS_EN
      ,
      .generated_count     (generated_count)
`endif
   );

   always #5 clock = ~clock;

   // Every accepted pop delivers the current head.
   always @(negedge clock) begin
      if (!rst_in && index_request && index_buffer_status.valid) got.push_back(output_index);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic build_model(input logic [63:0] b, input int unsigned ni, input int unsigned nj,
                              input logic [63:0] os, input logic [63:0] is);
      exp_q.delete();
      for (int unsigned i = 0; i < ni; i++)
         for (int unsigned j = 0; j < nj; j++)
            exp_q.push_back(b + 64'(i) * os + 64'(j) * is);
   endtask

   task automatic launch(input logic [63:0] b, input int unsigned ni, input int unsigned nj,
                         input logic [63:0] os, input logic [63:0] is);
      @(posedge clock); #1;
      base_index   = b;
      outer_count  = 32'(ni);
      inner_count  = 32'(nj);
      outer_stride = os;
      inner_stride = is;
      start_in     = 1'b1;
      @(posedge clock); #1;
      start_in     = 1'b0;
   endtask

   task automatic run_to_done(input bit rand_req, input bit noise, input string tag);
      bit ok = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clock); #1;
         if (index_done) begin
            ok = 1'b1;
            break;
         end
         index_request = rand_req ? ($urandom_range(0, 1) == 1) : 1'b1;
         start_in = noise && busy && ($urandom_range(0, 5) == 0);
         if (start_in) base_index = {$urandom(), $urandom()};
      end
      start_in = 1'b0;
      if (!ok) check({tag, "_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic compare_seq(input string tag);
      check({tag, "_len"}, 64'(got.size()), 64'(exp_q.size()));
      for (int k = 0; k < exp_q.size(); k++)
         check($sformatf("%s[%0d]", tag, k), (k < got.size()) ? got[k] : 64'hx, exp_q[k]);
   endtask

   initial begin
      int unsigned n0;
      logic [63:0] rb, ros, ris;
      int unsigned ri, rj;

      repeat (3) @(posedge clock);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(index_done), 64'd0);
      check("rst_empty", 64'(index_buffer_status.empty), 64'd1);
      check("rst_valid", 64'(index_buffer_status.valid), 64'd0);
      check("rst_full", 64'(index_buffer_status.full), 64'd0);
      check("rst_alfull", 64'(index_buffer_status.alfull), 64'd0);
      check("rst_out", output_index, 64'd0);
      rst_in = 1'b0;
      repeat (3) @(posedge clock);

      // Basic 2x3 nest with request held high, including first-index latency.
      index_request = 1'b1;
      got.delete();
      build_model(64'h1000, 2, 3, 64'h100, 64'h8);
      launch(64'h1000, 2, 3, 64'h100, 64'h8);
      check("setup_busy", 64'(busy), 64'd1);
      @(posedge clock); #1;
      check("lat_valid_early", 64'(index_buffer_status.valid), 64'd0);
      @(posedge clock); #1;
      check("lat_valid", 64'(index_buffer_status.valid), 64'd1);
      check("lat_first", output_index, 64'h1000);
      run_to_done(1'b0, 1'b0, "basic");
      compare_seq("basic");
      check("basic_done", 64'(index_done), 64'd1);
      check("basic_busy", 64'(busy), 64'd0);

      // Zero outer count: no pushes, done quickly.
      got.delete();
      launch(64'h42, 0, 5, 64'h1, 64'h1);
      for (int c = 0; c < 2; c++) begin
         check("zero_empty", 64'(index_buffer_status.empty), 64'd1);
         @(posedge clock); #1;
      end
      check("zero_done", 64'(index_done), 64'd1);
      check("zero_empty_end", 64'(index_buffer_status.empty), 64'd1);
      check("zero_pops", 64'(got.size()), 64'd0);

      // Back-pressure: no pops until generation stalls at alfull.
      index_request = 1'b0;
      got.delete();
      build_model(64'h8000, 1, 100, 64'h0, 64'h10);
      launch(64'h8000, 1, 100, 64'h0, 64'h10);
      repeat (60) @(posedge clock);
      #1;
      check("stall_alfull", 64'(index_buffer_status.alfull), 64'd1);
      check("stall_busy", 64'(busy), 64'd1);
      check("stall_notdone", 64'(index_done), 64'd0);
      check("stall_head", output_index, 64'h8000);
      run_to_done(1'b0, 1'b0, "stall");
      compare_seq("stall");

      // Address wrap modulo 2^64.
      got.delete();
      build_model(64'hFFFF_FFFF_FFFF_FFF8, 1, 2, 64'h0, 64'h8);
      launch(64'hFFFF_FFFF_FFFF_FFF8, 1, 2, 64'h0, 64'h8);
      run_to_done(1'b0, 1'b0, "wrap");
      compare_seq("wrap");

      // Reset in the middle of generation, then restart.
      index_request = 1'b1;
      launch(64'h5000, 4, 8, 64'h1000, 64'h4);
      repeat (6) @(posedge clock);
      #1;
      rst_in = 1'b1;
      #1;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_empty", 64'(index_buffer_status.empty), 64'd1);
      check("midrst_out", output_index, 64'd0);
      @(posedge clock); #1;
      check("midrst_busy_next", 64'(busy), 64'd0);
      rst_in = 1'b0;
      repeat (3) @(posedge clock);
      got.delete();
      build_model(64'h5000, 4, 8, 64'h1000, 64'h4);
      launch(64'h5000, 4, 8, 64'h1000, 64'h4);
      run_to_done(1'b1, 1'b0, "restart");
      compare_seq("restart");

      // Five-cycle freeze mid-generation.
      got.delete();
      index_request = 1'b1;
      build_model(64'h2000, 3, 4, 64'h40, 64'h4);
      launch(64'h2000, 3, 4, 64'h40, 64'h4);
      repeat (3) @(posedge clock);
      #1;
      enabled_in = 1'b0;
      n0 = got.size();
      repeat (5) @(posedge clock);
      #1;
      check("freeze_pushes", 64'((got.size() - n0) <= 1), 64'd1);
      check("freeze_busy", 64'(busy), 64'd1);
      enabled_in = 1'b1;
      run_to_done(1'b0, 1'b0, "freeze");
      compare_seq("freeze");
`ifdef TILED_LOOP_GEN_STATS_EN
      check("freeze_count", generated_count, 64'd12);
`endif

      // Random nests with random pops and stray start pulses that must be ignored.
      for (int r = 0; r < 5; r++) begin
         rb  = {$urandom(), $urandom()};
         ros = {$urandom(), $urandom()};
         ris = 64'($urandom_range(0, 4095));
         ri  = $urandom_range(1, 5);
         rj  = $urandom_range(1, 6);
         got.delete();
         build_model(rb, ri, rj, ros, ris);
         launch(rb, ri, rj, ros, ris);
         run_to_done(1'b1, 1'b1, $sformatf("rand%0d", r));
         compare_seq($sformatf("rand%0d", r));
         check($sformatf("rand%0d_done", r), 64'(index_done), 64'd1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tiled_loop_index_generator.md
TILED_LOOP_INDEX_GENERATOR -- requirements
Module: tiled_loop_index_generator

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 64, width of all index, base and stride values.
REQ-002 SHALL have parameter COUNT_WIDTH, default 32, width of the outer and inner trip counts.
REQ-003 SHALL have parameter FIFO_DEPTH, default 32, output FIFO entries (power of two, >=4).
REQ-004 SHALL have port clock  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port enabled_in  input  1  FSM advances only when high.
REQ-007 SHALL have port start_in  input  1  one-cycle pulse launching a loop nest.
REQ-008 SHALL have port base_index  input  INDEX_WIDTH  first index.
REQ-009 SHALL have port outer_count / inner_count  input  COUNT_WIDTH each  trip counts I, J.
REQ-010 SHALL have port outer_stride / inner_stride  input  INDEX_WIDTH each  displacement per i / j step.
REQ-011 SHALL have port index_request  input  1  pop one index from the FIFO.
REQ-012 SHALL have port index_buffer_status  output  BufferStatus  FIFO full/alfull/valid/empty.
REQ-013 SHALL have port output_index  output  INDEX_WIDTH  FIFO head data.
REQ-014 SHALL have port busy  output  1  nest active (state other than IDLE/DONE).
REQ-015 SHALL have port index_done  output  1  all indices pushed and FIFO empty.

Function
REQ-016 SHALL produce, for i in 0..I-1 (outer) and j in 0..J-1 (inner, fastest), index = base + i*outer_stride + j*inner_stride, modulo 2^INDEX_WIDTH.
REQ-017 SHALL compute indices by accumulation (row accumulator + column accumulator); no multipliers.
REQ-018 SHALL implement FSM states IDLE, SETUP, GEN, DRAIN, DONE.
REQ-019 IDLE -> SETUP on start_in && enabled_in; all inputs latched that cycle; start_in in other states ignored.
REQ-020 SETUP -> DONE if I==0 or J==0 (zero pushes), else -> GEN; accumulators load base.
REQ-021 GEN SHALL push one index per cycle while FIFO alfull is low; alfull high stalls without loss or duplication.
REQ-022 GEN: j wraps to 0 and i increments when j==J-1; after push of (I-1,J-1) -> DRAIN.
REQ-023 DRAIN -> DONE when FIFO empty; DONE -> SETUP on a new start_in, else holds.
REQ-024 First index SHALL be pushed 2 cycles after start_in and valid at output_index 1 cycle after push.
REQ-025 FIFO SHALL ignore pops when empty and never receive pushes when full; simultaneous push and pop SHALL both take effect.
REQ-026 enabled_in low SHALL freeze FSM, counters and pushes; pops still served.
REQ-027 index_done SHALL be high only in DONE; busy high in SETUP, GEN, DRAIN.

Reset
REQ-028 rst_in high SHALL, at any time, force IDLE, clear counters/accumulators, flush FIFO; outputs: busy 0, index_done 0, status empty 1, valid/full/alfull 0, output_index 0.
REQ-029 Reset SHALL be synchronised for deassertion internally (async assert, sync release).

Configuration
REQ-030 Macro TILED_LOOP_GEN_STATS_EN defined: add output generated_count (COUNT_WIDTH*2 bits), counting pushes since last start, cleared on start and reset, saturating.
REQ-031 Macro undefined: generated_count port and its counter absent; all other behaviour identical.

Structure
REQ-032 FSM enum tiled_loop_index_gen_state SHALL live in CU_PKG; BufferStatus reused from CU_PKG.
REQ-033 Output buffer SHALL be the existing fifo sub-module (WIDTH=INDEX_WIDTH, DEPTH=FIFO_DEPTH); no other sub-modules.

Verification
REQ-034 base=0x1000, I=2, J=3, outer_stride=0x100, inner_stride=8, request held high -> 0x1000,0x1008,0x1010,0x1100,0x1108,0x1110 in order, then index_done=1.
REQ-035 I=0, J=5 -> no pushes, index_done within 3 cycles of start, status empty stays 1.
REQ-036 I=1, J=100, FIFO_DEPTH=32, no requests -> pushes stop at alfull; then pop all -> 100 unique indices, none lost.
REQ-037 base=0xFFFF_FFFF_FFFF_FFF8, J=2, inner_stride=8 -> 0xFFFF_FFFF_FFFF_FFF8, 0x0 (wrap).
REQ-038 rst_in asserted mid-GEN -> next cycle busy 0, status empty 1; new start produces sequence from base again.
REQ-039 enabled_in low for 5 cycles mid-GEN -> no pushes during freeze; sequence resumes without gap (with STATS_EN, generated_count=I*J at DONE).
